// File: rtl/rv32_dmem_if.sv
// rv32_dmem_if: data-port bundle between the RV32I core and rv32_dmem.
//
// Signals:
//   dmAddress  byte address from the core
//   dmFunc3    access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
//   dmWrite    store strobe for the current cycle
//   dmDataOut  store data from the core, LSB-aligned
//   dmDataIn   registered load data back to the core
//
// The data port has no handshake: the core presents a new access every
// cycle, stores commit at the closing edge, and load data is valid for the
// whole of the following cycle.
//
// Modports: master = core side, slave = memory side.
interface rv32_dmem_if;
  logic [31:0] dmAddress;
  logic [2:0]  dmFunc3;
  logic        dmWrite;
  logic [31:0] dmDataOut;
  logic [31:0] dmDataIn;

  modport master (output dmAddress, output dmFunc3, output dmWrite,
                  output dmDataOut, input dmDataIn);
  modport slave  (input dmAddress, input dmFunc3, input dmWrite,
                  input dmDataOut, output dmDataIn);
endinterface

// File: rtl/rv32_dmem.sv
// rv32_dmem: synchronous data memory for the RV32I core's data port.
// Stores commit at the clock edge; loads return sign/zero-extended data one
// cycle later (registered). Misaligned or illegal accesses raise a sticky
// fault and record the address of the first one.
//
// Optional feature macro: RV32_DMEM_MMIO_EN. When defined, dmAddress[31]=1
// selects an MMIO window: 0x0 console push (W), 0x4 status (R), 0x8 cycle
// counter (R). When undefined, bit 31 simply aliases into RAM.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   dm (slave)        core data port, see rv32_dmem_if
//   fault, faultAddr  sticky fault flag and first faulting address
//   conTxData/Valid   console FIFO head byte and non-empty flag
//   conTxReady        consumer takes the head byte when high with conTxValid
//                     (valid/ready: a byte transfers on any edge where both
//                     are high; valid never depends on ready)
module rv32_dmem #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic         clock,
  input  logic         reset,
  rv32_dmem_if.slave   dm,
  output logic         fault,
  output logic [31:0]  faultAddr,
  output logic [7:0]   conTxData,
  output logic         conTxValid,
  input  logic         conTxReady
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   addr;
  logic [2:0]    f3;
  logic [AW-1:0] word_idx;
  logic          mmio_sel;
  logic [31:0]   mmio_rdata;

  assign addr     = dm.dmAddress;
  assign f3       = dm.dmFunc3;
  assign word_idx = addr[AW+1:2];

  // ---------------- access legality ----------------
  logic misaligned, illegal, access_fault;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (f3)
      3'd0, 3'd4: misaligned = 1'b0;
      3'd1, 3'd5: misaligned = addr[0];
      3'd2:       misaligned = |addr[1:0];
      default:    illegal    = 1'b1;
    endcase
    // Stores only know SB/SH/SW; the unsigned codes are load-only.
    if (dm.dmWrite && f3[2]) illegal = 1'b1;
    // MMIO registers are word-wide; narrower accesses are rejected.
    if (mmio_sel && (f3[1:0] != 2'd2)) misaligned = 1'b1;
    access_fault = misaligned | illegal;
  end

  // ---------------- store path ----------------
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ram_we;

  always_comb begin
    wstrb = 4'b1111;
    wdata = dm.dmDataOut;
    case (f3[1:0])
      2'd0: begin
        wstrb = 4'b0001 << addr[1:0];
        wdata = {4{dm.dmDataOut[7:0]}};
      end
      2'd1: begin
        wstrb = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{dm.dmDataOut[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = dm.dmDataOut;
      end
    endcase
  end

  assign ram_we = dm.dmWrite && !access_fault && !mmio_sel;

  // No reset on the array; the reset gate only blocks a store that lands on
  // an edge while reset is held.
  always_ff @(posedge clock) begin
    if (!reset && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- load path ----------------
  logic [31:0] ram_word, shifted, ram_ext, load_value, data_q;

  assign ram_word = mem[word_idx];
  assign shifted  = ram_word >> {addr[1:0], 3'b000};

  always_comb begin
    ram_ext = shifted;
    case (f3)
      3'd0:    ram_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    ram_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    ram_ext = {24'd0, shifted[7:0]};
      3'd5:    ram_ext = {16'd0, shifted[15:0]};
      default: ram_ext = shifted;
    endcase
    if (access_fault)  load_value = 32'd0;
    else if (mmio_sel) load_value = mmio_rdata;
    else               load_value = ram_ext;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q    <= 32'd0;
      fault     <= 1'b0;
      faultAddr <= 32'd0;
    end else begin
      if (!dm.dmWrite) data_q <= load_value;
      if (access_fault) begin
        fault <= 1'b1;
        if (!fault) faultAddr <= addr;
      end
    end
  end

  assign dm.dmDataIn = data_q;

`ifdef RV32_DMEM_MMIO_EN
  // ---------------- MMIO: console FIFO and cycle counter ----------------
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        overflow;
  logic [31:0] cycle_count;
  logic        fifo_full, fifo_empty, push, pop, push_ok;

  assign mmio_sel   = addr[31];
  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  assign pop        = conTxValid && conTxReady;
  assign push       = dm.dmWrite && mmio_sel && !access_fault && (addr[3:2] == 2'd0);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      count       <= 3'd0;
      overflow    <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'd0, push_ok} - {2'd0, pop};
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= dm.dmDataOut[7:0];
  end

  assign conTxValid = !fifo_empty;
  assign conTxData  = fifo_empty ? 8'd0 : fifo_mem[rd_ptr];

  always_comb begin
    case (addr[3:2])
      2'd1:    mmio_rdata = {28'd0, overflow, fault, fifo_empty, fifo_full};
      2'd2:    mmio_rdata = cycle_count;
      default: mmio_rdata = 32'd0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{addr[30:AW+2]};
`else
  assign mmio_sel   = 1'b0;
  assign mmio_rdata = 32'd0;
  assign conTxValid = 1'b0;
  assign conTxData  = 8'd0;

  logic unused_bits;
  assign unused_bits = ^{addr[31:AW+2], conTxReady};
`endif

endmodule

// File: tb/tb_rv32_dmem.sv
// tb_rv32_dmem: randomized self-checking bench for rv32_dmem. A byte-array
// memory plus a queue-based console model predict every load result, the
// fault flags and the console outputs.
module tb_rv32_dmem;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rv32_dmem_if bus ();
  logic        fault;
  logic [31:0] faultAddr;
  logic [7:0]  conTxData;
  logic        conTxValid;
  logic        conTxReady;

  rv32_dmem #(.DEPTH_WORDS(1024), .INIT_FILE("")) dut (
    .clock      (clock),
    .reset      (reset),
    .dm         (bus.slave),
    .fault      (fault),
    .faultAddr  (faultAddr),
    .conTxData  (conTxData),
    .conTxValid (conTxValid),
    .conTxReady (conTxReady)
  );

  // ---------------- reference model ----------------
  logic [7:0]  ram_b [4096];
  logic [31:0] exp_data;
  logic        exp_fault;
  logic [31:0] exp_faddr;
  logic [7:0]  con_q [$];
  logic        con_ovf;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] a);
`ifdef RV32_DMEM_MMIO_EN
    return a[31];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    bit bad;
    bad = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    if ((a % size_of(f3)) != 0) bad = 1'b1;
    if (is_mmio(a) && size_of(f3) != 4) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int sz = size_of(f3);
    for (int i = 0; i < sz; i++) v = v + (longint'(ram_b[(a + i) & 32'hFFF]) << (8 * i));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // One bus cycle: drive, update the model, clock, then compare.
  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input bit chk);
    bit flt;
    bus.dmWrite   = wr;
    bus.dmFunc3   = f3;
    bus.dmAddress = a;
    bus.dmDataOut = d;
    flt = model_fault(wr, f3, a);
    if (conTxReady && con_q.size() != 0) void'(con_q.pop_front());
    if (wr) begin
      if (!flt) begin
        if (is_mmio(a)) begin
          if (a[3:2] == 2'd0) begin
            if (con_q.size() < 4) con_q.push_back(d[7:0]);
            else con_ovf = 1'b1;
          end
        end else begin
          for (int i = 0; i < size_of(f3); i++) ram_b[(a + i) & 32'hFFF] = d[8*i +: 8];
        end
      end
    end else if (flt) begin
      exp_data = 32'd0;
    end else if (is_mmio(a)) begin
      exp_data = (a[3:2] == 2'd1) ?
        {28'd0, con_ovf, exp_fault, con_q.size() == 0, con_q.size() == 4} : 32'd0;
    end else begin
      exp_data = model_load(f3, a);
    end
    if (flt && !exp_fault) begin
      exp_fault = 1'b1;
      exp_faddr = a;
    end
    exp_q.push_back(exp_data);
    @(posedge clock);
    #1;
    if (chk) check("dmDataIn", bus.dmDataIn, exp_q.pop_front());
    else void'(exp_q.pop_front());
    check("fault", {31'd0, fault}, {31'd0, exp_fault});
    check("faultAddr", faultAddr, exp_faddr);
    check("conTxValid", {31'd0, conTxValid}, {31'd0, con_q.size() != 0});
    check("conTxData", {24'd0, conTxData}, (con_q.size() != 0) ? {24'd0, con_q[0]} : 32'd0);
  endtask

  task automatic idle();
    do_access(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3_tab [8];
    logic [31:0] a, d, v1, v2;
    logic [2:0]  f3;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd1};

    reset = 1'b1;
    conTxReady = 1'b0;
    bus.dmWrite = 1'b0; bus.dmFunc3 = 3'd2; bus.dmAddress = 32'h0; bus.dmDataOut = 32'h0;
    exp_data = 32'd0; exp_fault = 1'b0; exp_faddr = 32'd0; con_ovf = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_dmDataIn", bus.dmDataIn, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_faultAddr", faultAddr, 32'd0);
    check("rst_conTxValid", {31'd0, conTxValid}, 32'd0);
    check("rst_conTxData", {24'd0, conTxData}, 32'd0);
    reset = 1'b0;

    // Fill the 16-word working region so random loads never see X.
    for (int w = 0; w < 16; w++) do_access(1'b1, 3'd2, w * 4, $urandom, 1'b1);

    // Directed lane-select sequence.
    do_access(1'b1, 3'd2, 32'h10, 32'h12345678, 1'b1);
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    check("lw_0x10", bus.dmDataIn, 32'h12345678);
    do_access(1'b0, 3'd0, 32'h13, 32'h0, 1'b1);
    check("lb_0x13", bus.dmDataIn, 32'h00000012);
    do_access(1'b1, 3'd0, 32'h10, 32'h80, 1'b1);
    check("hold_on_store", bus.dmDataIn, 32'h00000012);
    do_access(1'b0, 3'd0, 32'h10, 32'h0, 1'b1);
    check("lb_neg", bus.dmDataIn, 32'hFFFFFF80);
    do_access(1'b0, 3'd4, 32'h10, 32'h0, 1'b1);
    check("lbu", bus.dmDataIn, 32'h00000080);
    do_access(1'b1, 3'd1, 32'h12, 32'hBEEF, 1'b1);
    do_access(1'b0, 3'd1, 32'h12, 32'h0, 1'b1);
    check("lh_neg", bus.dmDataIn, 32'hFFFFBEEF);
    do_access(1'b0, 3'd5, 32'h12, 32'h0, 1'b1);
    check("lhu", bus.dmDataIn, 32'h0000BEEF);
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    check("lw_merged", bus.dmDataIn, 32'hBEEF5680);

    // Faults.
    do_access(1'b1, 3'd2, 32'h21, 32'hCAFEF00D, 1'b1);
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_addr", faultAddr, 32'h21);
    do_access(1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    do_access(1'b0, 3'd1, 32'h33, 32'h0, 1'b1);
    check("fault_addr_kept", faultAddr, 32'h21);
    check("mis_load_zero", bus.dmDataIn, 32'd0);
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    do_access(1'b0, 3'd3, 32'h10, 32'h0, 1'b1);
    check("illegal_load_zero", bus.dmDataIn, 32'd0);

`ifndef RV32_DMEM_MMIO_EN
    // Bit 31 aliases into RAM without the MMIO window.
    do_access(1'b1, 3'd2, 32'h80000024, 32'hA5A5_1234, 1'b1);
    do_access(1'b0, 3'd2, 32'h24, 32'h0, 1'b1);
    check("alias_bit31", bus.dmDataIn, 32'hA5A5_1234);
`endif

    // Randomized traffic over the working region, with upper-bit aliasing.
    for (int n = 0; n < 400; n++) begin
      f3 = f3_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 31) == 0) f3 = 3'd3 + 3'($urandom_range(0, 1) * 3);
      a = $urandom_range(0, 63) | ($urandom_range(0, 7) << 12);
`ifndef RV32_DMEM_MMIO_EN
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
`endif
      d = $urandom;
      do_access(1'($urandom_range(0, 2) == 0), f3, a, d, 1'b1);
    end

    // Reset in the middle of a pending load; a store during reset is dropped.
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    bus.dmWrite = 1'b0; bus.dmFunc3 = 3'd2; bus.dmAddress = 32'h10;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_data", bus.dmDataIn, 32'd0);
    check("rst_mid_fault", {31'd0, fault}, 32'd0);
    bus.dmWrite = 1'b1; bus.dmAddress = 32'h14; bus.dmDataOut = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    bus.dmWrite = 1'b0; bus.dmAddress = 32'h0;
    reset = 1'b0;
    exp_data = 32'd0; exp_fault = 1'b0; exp_faddr = 32'd0;
    con_q.delete(); con_ovf = 1'b0;
    check("rst_faultAddr2", faultAddr, 32'd0);
    do_access(1'b0, 3'd2, 32'h14, 32'h0, 1'b1);
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 1'b1);

`ifdef RV32_DMEM_MMIO_EN
    // Console FIFO: fill past capacity while the consumer stalls.
    conTxReady = 1'b0;
    do_access(1'b1, 3'd2, 32'h80000000, 32'h41, 1'b1);
    check("first_push_valid", {31'd0, conTxValid}, 32'd1);
    check("first_push_data", {24'd0, conTxData}, 32'h41);
    for (int c = 1; c < 5; c++) do_access(1'b1, 3'd2, 32'h80000000, 32'h41 + c, 1'b1);
    do_access(1'b0, 3'd2, 32'h80000004, 32'h0, 1'b1);
    check("status_full_ovf", bus.dmDataIn, 32'h9);
    do_access(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
    conTxReady = 1'b1;
    for (int k = 0; k < 8 && con_q.size() != 0; k++) idle();
    check("drained_valid", {31'd0, conTxValid}, 32'd0);
    conTxReady = 1'b0;

    // Cycle counter: two reads five cycles apart.
    do_access(1'b0, 3'd2, 32'h80000008, 32'h0, 1'b0);
    v1 = bus.dmDataIn;
    repeat (4) idle();
    do_access(1'b0, 3'd2, 32'h80000008, 32'h0, 1'b0);
    v2 = bus.dmDataIn;
    check("counter_delta", v2 - v1, 32'd5);
    idle();

    // Narrow access to MMIO is a fault and pushes nothing.
    do_access(1'b1, 3'd0, 32'h80000000, 32'h5A, 1'b1);
    check("mmio_sb_fault", {31'd0, fault}, 32'd1);
    do_access(1'b0, 3'd2, 32'h80000004, 32'h0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
